acc_requant_drain: RTL and testbench
====================================

Name: acc_requant_drain

Overview:
- Sits directly downstream of the DSP accumulation group.
- Captures one final N_KERNEL-wide vector of 2*B_PIXEL-bit accumulator sums in a single handshake.
- Rescales each channel with a rounding arithmetic right shift, saturates it to B_PIXEL bits, and streams the channels out one per beat over a valid/ready interface toward the output-feature-map writer.
- Shares the group's clk_en freeze semantics.

Parameters:
- N_KERNEL, 3, number of channels per captured vector (same as the DSP group).
- B_PIXEL, 16, output pixel width; each input channel is 2*B_PIXEL bits.
- B_SHIFT, 5, shift-amount width; must satisfy 2^B_SHIFT >= 2*B_PIXEL.

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- clk_en  in  1  global advance enable; when 0 all state holds.
- acc_i  in  2*B_PIXEL*N_KERNEL  final signed sums; channel j at [j*2*B_PIXEL +: 2*B_PIXEL].
- acc_vld  in  1  acc_i and shift are valid this cycle.
- acc_rdy  out  1  block can accept a vector.
- shift  in  B_SHIFT  right-shift amount, unsigned; captured with acc_i.
- dout  out  B_PIXEL  signed requantised channel value.
- dout_vld  out  1  dout valid.
- dout_rdy  in  1  downstream accepts dout.
- dout_last  out  1  qualifies the final channel (N_KERNEL-1) of a vector.

Behaviour:
- Reset (rst=1 at an edge, regardless of clk_en):
  - state=IDLE, acc_rdy=1, dout_vld=0, dout_last=0, dout=0, channel index=0.
  - Any in-flight vector is discarded.
- Freeze: while clk_en=0, no register changes and no handshake completes, even if vld&rdy are both high.
- States:
  - IDLE: acc_rdy=1. Input handshake = acc_vld & acc_rdy & clk_en at an edge. On it: latch acc_i and shift, idx<=0, go to DRAIN. acc_rdy=0 from the next cycle.
  - DRAIN: acc_rdy=0 and acc_vld is ignored. The output register loads channel idx when (!dout_vld | dout_rdy) & clk_en and channels remain; idx then increments.
  - Leaving DRAIN: when the beat with dout_last=1 handshakes, go to IDLE. acc_rdy=1 in the following cycle and dout_vld=0 unless a new vector is loaded later.
- Latency and throughput:
  - Handshake at edge k gives dout_vld=1 from edge k+1 (channel 0).
  - With dout_rdy held at 1, channels 0..N_KERNEL-1 appear on consecutive cycles.
  - Minimum period per vector is N_KERNEL+1 cycles; vectors do not overlap.
- Output ordering: channel 0 first; dout_last=1 only with channel N_KERNEL-1.
- Backpressure: while dout_vld=1 & dout_rdy=0, dout, dout_last and idx hold unchanged.
- Arithmetic, per channel, with s = min(shift, 2*B_PIXEL-1):
  - Sign-extend the channel to 2*B_PIXEL+1 bits.
  - Add 2^(s-1) if s>0 (round half up).
  - Arithmetic shift right by s.
  - Saturate to [-2^(B_PIXEL-1), 2^(B_PIXEL-1)-1]. No wrap-around is permitted.
- Shift clamp: shift >= 2*B_PIXEL behaves exactly as 2*B_PIXEL-1.
- rst and clk_en=0 simultaneously: rst wins.
- acc_vld with rst=1: ignored.

Optional Feature:
- Macro: ACC_REQUANT_RELU_EN.
- When defined:
  - Adds input port relu (1 bit), captured together with acc_i.
  - If the captured relu=1, any negative saturated result is output as 0.
  - ReLU is applied after saturation; latency is unchanged.
- When undefined: the port is absent and results pass through signed.

Test Plan:
- Reset → hold rst 2 cycles with clk_en=1 → acc_rdy=1, dout_vld=0, dout=0, dout_last=0.
- Nominal → ch0=100, ch1=-1, ch2=0x300, shift=2, dout_rdy=1 → next 3 cycles dout=0x0019, 0x0000, 0x00C0; dout_last only on the 3rd beat; acc_rdy=1 the cycle after.
- Saturation and clamp → ch0=0x00010000, ch1=0xFFFE0000 with shift=0 → 0x7FFF, 0x8000. Then ch2=0x7FFFFFFF with shift=31 → 0x0001, and the same vector with shift=31 (max 5-bit value) gives identical output.
- Backpressure → drop dout_rdy for 3 cycles after the first beat and pulse acc_vld meanwhile → dout stays 0x0019, acc_rdy stays 0, the pulse is ignored; beats resume on release.
- Freeze and reset → clk_en=0 for 2 cycles mid-drain holds all outputs even with dout_rdy=1. Then rst mid-drain → next cycle dout_vld=0, acc_rdy=1, and a fresh vector drains correctly.
- ReLU (macro defined) → ch0=-400, ch1=5, ch2=-1, shift=0, relu=1 → 0x0000, 0x0005, 0x0000. With relu=0 → 0xFE70, 0x0005, 0xFFFF.

Source files
------------

// File: rtl/acc_requant_drain_if.sv
// acc_requant_drain_if: bundles the vector-capture and channel-stream handshakes
// of acc_requant_drain.
//   acc_i / shift / acc_vld / acc_rdy : one N_KERNEL-wide vector of 2*B_PIXEL-bit
//                                       signed sums plus its right-shift amount
//   relu                              : ReLU request captured with the vector
//                                       (only when ACC_REQUANT_RELU_EN is defined)
//   dout / dout_vld / dout_rdy / dout_last : one requantised channel per beat
// Modports: slave = the requant block, master = the surrounding environment.
interface acc_requant_drain_if #(
  parameter int unsigned N_KERNEL = 3,
  parameter int unsigned B_PIXEL  = 16,
  parameter int unsigned B_SHIFT  = 5
);
  logic [2*B_PIXEL*N_KERNEL-1:0] acc_i;
  logic                          acc_vld;
  logic                          acc_rdy;
  logic [B_SHIFT-1:0]            shift;
`ifdef ACC_REQUANT_RELU_EN
  logic                          relu;
`endif
  logic [B_PIXEL-1:0]            dout;
  logic                          dout_vld;
  logic                          dout_rdy;
  logic                          dout_last;

  modport slave (
    input  acc_i, acc_vld, shift,
`ifdef ACC_REQUANT_RELU_EN
    input  relu,
`endif
    input  dout_rdy,
    output acc_rdy, dout, dout_vld, dout_last
  );

  modport master (
    output acc_i, acc_vld, shift,
`ifdef ACC_REQUANT_RELU_EN
    output relu,
`endif
    output dout_rdy,
    input  acc_rdy, dout, dout_vld, dout_last
  );
endinterface

// File: rtl/acc_requant_drain.sv
// acc_requant_drain: captures one vector of accumulator sums, then streams each
// channel out after a rounding arithmetic right shift and saturation to B_PIXEL.
// Ports:
//   clk     : rising-edge clock
//   rst     : synchronous active-high reset (wins over clk_en)
//   clk_en  : global advance enable; all state holds while low
//   bus     : acc_requant_drain_if.slave (vector in, channel stream out)
// Optional: define ACC_REQUANT_RELU_EN to add a captured relu bit that forces
// negative saturated results to zero.
module acc_requant_drain #(
  parameter int unsigned N_KERNEL = 3,
  parameter int unsigned B_PIXEL  = 16,
  parameter int unsigned B_SHIFT  = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clk_en,
  acc_requant_drain_if.slave   bus
);
  localparam int unsigned W_ACC = 2 * B_PIXEL;
  localparam int unsigned W_EXT = W_ACC + 1;
  localparam int unsigned W_VEC = W_ACC * N_KERNEL;
  localparam int unsigned W_IDX = $clog2(N_KERNEL + 1);
  localparam int unsigned S_MAX = W_ACC - 1;

  localparam logic signed [W_EXT-1:0] SAT_MAX = W_EXT'((2 ** (B_PIXEL - 1)) - 1);
  localparam logic signed [W_EXT-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  state_t               state;
  logic [W_VEC-1:0]     acc_q;
  logic [B_SHIFT-1:0]   shift_q;
  logic [W_IDX-1:0]     idx;       // next channel to load into the output register
  logic                 acc_rdy_q;
  logic [B_PIXEL-1:0]   dout_q;
  logic                 dout_vld_q;
  logic                 dout_last_q;
`ifdef ACC_REQUANT_RELU_EN
  logic                 relu_q;
  logic                 relu_sel;
`endif

  logic [W_ACC-1:0]        ch_sel;
  logic [B_SHIFT-1:0]      shift_sel;
  logic [B_SHIFT-1:0]      s_eff;
  logic signed [W_EXT-1:0] ext;
  logic signed [W_EXT-1:0] rnd;
  logic signed [W_EXT-1:0] sum;
  logic signed [W_EXT-1:0] shr;
  logic [B_PIXEL-1:0]      res;

  assign bus.acc_rdy   = acc_rdy_q;
  assign bus.dout      = dout_q;
  assign bus.dout_vld  = dout_vld_q;
  assign bus.dout_last = dout_last_q;

  // Operand select: in IDLE channel 0 comes straight from the input so it can be
  // loaded on the capture edge; in DRAIN the captured vector is indexed.
  always_comb begin
    ch_sel    = bus.acc_i[W_ACC-1:0];
    shift_sel = bus.shift;
`ifdef ACC_REQUANT_RELU_EN
    relu_sel  = bus.relu;
`endif
    if (state == DRAIN) begin
      ch_sel    = '0;
      shift_sel = shift_q;
`ifdef ACC_REQUANT_RELU_EN
      relu_sel  = relu_q;
`endif
      for (int j = 0; j < int'(N_KERNEL); j++) begin
        if (idx == W_IDX'(j)) ch_sel = acc_q[j*W_ACC +: W_ACC];
      end
    end
  end

  // Rounding shift and saturation; one extra bit keeps the rounding add exact.
  always_comb begin
    s_eff = (32'(shift_sel) > S_MAX) ? B_SHIFT'(S_MAX) : shift_sel;
    ext   = {ch_sel[W_ACC-1], ch_sel};
    rnd   = (s_eff == '0) ? '0 : (W_EXT'(1) << (s_eff - B_SHIFT'(1)));
    sum   = ext + rnd;
    shr   = sum >>> s_eff;
    if (shr > SAT_MAX) begin
      res = SAT_MAX[B_PIXEL-1:0];
    end else if (shr < SAT_MIN) begin
      res = SAT_MIN[B_PIXEL-1:0];
    end else begin
      res = shr[B_PIXEL-1:0];
    end
`ifdef ACC_REQUANT_RELU_EN
    if (relu_sel && res[B_PIXEL-1]) res = '0;
`endif
  end

  // Capture/drain state machine with registered handshake outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      acc_q       <= '0;
      shift_q     <= '0;
      idx         <= '0;
      acc_rdy_q   <= 1'b1;
      dout_q      <= '0;
      dout_vld_q  <= 1'b0;
      dout_last_q <= 1'b0;
`ifdef ACC_REQUANT_RELU_EN
      relu_q      <= 1'b0;
`endif
    end else if (clk_en) begin
      case (state)
        IDLE: begin
          if (bus.acc_vld) begin
            acc_q       <= bus.acc_i;
            shift_q     <= bus.shift;
`ifdef ACC_REQUANT_RELU_EN
            relu_q      <= bus.relu;
`endif
            dout_q      <= res;
            dout_vld_q  <= 1'b1;
            dout_last_q <= (N_KERNEL == 1);
            idx         <= W_IDX'(1);
            acc_rdy_q   <= 1'b0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (!dout_vld_q || bus.dout_rdy) begin
            if (idx < W_IDX'(N_KERNEL)) begin
              dout_q      <= res;
              dout_vld_q  <= 1'b1;
              dout_last_q <= (idx == W_IDX'(N_KERNEL - 1));
              idx         <= idx + W_IDX'(1);
            end else begin
              // Final beat accepted: vector complete.
              dout_vld_q  <= 1'b0;
              dout_last_q <= 1'b0;
              idx         <= '0;
              acc_rdy_q   <= 1'b1;
              state       <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_acc_requant_drain.sv
// Scoreboard bench for acc_requant_drain: expected beats are queued when a vector
// is offered and compared as the DUT hands each beat off.
module tb_acc_requant_drain;
  localparam int unsigned N_KERNEL = 3;
  localparam int unsigned B_PIXEL  = 16;
  localparam int unsigned B_SHIFT  = 5;

  typedef struct {
    logic [15:0] d;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clk_en = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  bit   rand_bp = 1'b0;
  beat_t sb[$];

  acc_requant_drain_if #(.N_KERNEL(N_KERNEL), .B_PIXEL(B_PIXEL), .B_SHIFT(B_SHIFT)) bus();

  acc_requant_drain #(.N_KERNEL(N_KERNEL), .B_PIXEL(B_PIXEL), .B_SHIFT(B_SHIFT)) dut (
    .clk    (clk),
    .rst    (rst),
    .clk_en (clk_en),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] model(input logic [31:0] a, input int sh, input bit relu);
    longint v;
    int s;
    s = (sh > 31) ? 31 : sh;
    v = longint'($signed(a));
    if (s > 0) v = v + (longint'(1) <<< (s - 1));
    v = v >>> s;
    if (v > 32767) v = 32767;
    else if (v < -32768) v = -32768;
    if (relu && v < 0) v = 0;
    return 16'(v);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Offer one vector and queue its expected beats.
  task automatic send_vec(input logic [31:0] a0, input logic [31:0] a1, input logic [31:0] a2,
                          input int sh, input bit relu,
                          input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2);
    int n;
    n = 0;
    while (!bus.acc_rdy && n < 100) begin
      tick();
      n++;
    end
    if (!bus.acc_rdy) check("acc_rdy timeout", 32'(bus.acc_rdy), 32'd1);
    bus.acc_i   = {a2, a1, a0};
    bus.shift   = B_SHIFT'(sh);
`ifdef ACC_REQUANT_RELU_EN
    bus.relu    = relu;
`endif
    bus.acc_vld = 1'b1;
    sb.push_back('{d: e0, last: 1'b0});
    sb.push_back('{d: e1, last: 1'b0});
    sb.push_back('{d: e2, last: 1'b1});
    tick();
    bus.acc_vld = 1'b0;
  endtask

  task automatic drain;
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.dout_vld) && n < 200) begin
      tick();
      n++;
    end
    check("drain empty", 32'(sb.size()), 32'd0);
  endtask

  // Beat monitor: a handshake will complete at the coming edge.
  always @(negedge clk) begin
    if (bus.dout_vld && bus.dout_rdy && clk_en && !rst) begin
      if (sb.size() == 0) begin
        check("unexpected beat", 32'(bus.dout), 32'hDEAD);
      end else begin
        beat_t b;
        b = sb.pop_front();
        check("dout", 32'(bus.dout), 32'(b.d));
        check("dout_last", 32'(bus.dout_last), 32'(b.last));
      end
    end
  end

  // Random backpressure when enabled.
  always @(posedge clk) begin
    if (rand_bp) begin
      #1;
      bus.dout_rdy = ($urandom_range(0, 3) != 0);
    end
  end

  initial begin
    bus.acc_i    = '0;
    bus.acc_vld  = 1'b0;
    bus.shift    = '0;
`ifdef ACC_REQUANT_RELU_EN
    bus.relu     = 1'b0;
`endif
    bus.dout_rdy = 1'b1;

    // Reset
    rst = 1'b1;
    tick();
    tick();
    check("rst acc_rdy", 32'(bus.acc_rdy), 32'd1);
    check("rst dout_vld", 32'(bus.dout_vld), 32'd0);
    check("rst dout", 32'(bus.dout), 32'd0);
    check("rst dout_last", 32'(bus.dout_last), 32'd0);
    rst = 1'b0;
    tick();

    // Nominal with latency/throughput timing
    send_vec(32'd100, 32'hFFFF_FFFF, 32'h0000_0300, 2, 1'b0, 16'h0019, 16'h0000, 16'h00C0);
    check("nom vld k+1", 32'(bus.dout_vld), 32'd1);
    check("nom acc_rdy busy", 32'(bus.acc_rdy), 32'd0);
    tick();
    tick();
    check("nom last beat vld", 32'(bus.dout_vld), 32'd1);
    check("nom last flag", 32'(bus.dout_last), 32'd1);
    tick();
    check("nom acc_rdy after", 32'(bus.acc_rdy), 32'd1);
    check("nom vld after", 32'(bus.dout_vld), 32'd0);
    drain();

    // Saturation and shift clamp
    send_vec(32'h0001_0000, 32'hFFFE_0000, 32'h0000_1234, 0, 1'b0, 16'h7FFF, 16'h8000, 16'h1234);
    drain();
    send_vec(32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 31, 1'b0, 16'hFFFF, 16'h0000, 16'h0001);
    drain();
    send_vec(32'h8000_0000, 32'h0000_0000, 32'h7FFF_FFFF, 31, 1'b0, 16'hFFFF, 16'h0000, 16'h0001);
    drain();

    // Backpressure with an ignored acc_vld pulse
    send_vec(32'd100, 32'hFFFF_FFFF, 32'h0000_0300, 2, 1'b0, 16'h0019, 16'h0000, 16'h00C0);
    bus.dout_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) begin
        bus.acc_i   = {32'd7, 32'd7, 32'd7};
        bus.shift   = '0;
        bus.acc_vld = 1'b1;
      end
      tick();
      bus.acc_vld = 1'b0;
      check("bp dout hold", 32'(bus.dout), 32'h0019);
      check("bp vld hold", 32'(bus.dout_vld), 32'd1);
      check("bp last hold", 32'(bus.dout_last), 32'd0);
      check("bp acc_rdy", 32'(bus.acc_rdy), 32'd0);
    end
    bus.dout_rdy = 1'b1;
    drain();

    // Freeze mid-drain, then reset mid-drain
    send_vec(32'd100, 32'hFFFF_FFFF, 32'h0000_0300, 2, 1'b0, 16'h0019, 16'h0000, 16'h00C0);
    clk_en = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      check("frz dout", 32'(bus.dout), 32'h0019);
      check("frz vld", 32'(bus.dout_vld), 32'd1);
      check("frz acc_rdy", 32'(bus.acc_rdy), 32'd0);
    end
    clk_en = 1'b1;
    tick();
    check("frz resume", 32'(bus.dout), 32'h0000);
    rst         = 1'b1;
    clk_en      = 1'b0;
    bus.acc_i   = {32'd9, 32'd9, 32'd9};
    bus.acc_vld = 1'b1;
    tick();
    rst         = 1'b0;
    clk_en      = 1'b1;
    bus.acc_vld = 1'b0;
    sb.delete();
    check("mid rst vld", 32'(bus.dout_vld), 32'd0);
    check("mid rst acc_rdy", 32'(bus.acc_rdy), 32'd1);
    check("mid rst last", 32'(bus.dout_last), 32'd0);
    send_vec(32'd64, 32'hFFFF_FFC0, 32'd5, 3, 1'b0, 16'h0008, 16'hFFF8, 16'h0001);
    drain();

`ifdef ACC_REQUANT_RELU_EN
    // ReLU
    send_vec(32'hFFFF_FE70, 32'd5, 32'hFFFF_FFFF, 0, 1'b1, 16'h0000, 16'h0005, 16'h0000);
    drain();
    send_vec(32'hFFFF_FE70, 32'd5, 32'hFFFF_FFFF, 0, 1'b0, 16'hFE70, 16'h0005, 16'hFFFF);
    drain();
`endif

    // Random vectors under random backpressure
    rand_bp = 1'b1;
    for (int v = 0; v < 12; v++) begin
      logic [31:0] a[3];
      int sh;
      for (int c = 0; c < 3; c++) begin
        a[c] = (v % 2 == 0) ? 32'($signed(16'($urandom))) * 32'd37 : 32'($urandom);
      end
      sh = $urandom_range(0, 31);
      send_vec(a[0], a[1], a[2], sh, 1'b0,
               model(a[0], sh, 1'b0), model(a[1], sh, 1'b0), model(a[2], sh, 1'b0));
    end
    drain();
    rand_bp = 1'b0;
    tick();
    bus.dout_rdy = 1'b1;
    tick();
    check("final idle acc_rdy", 32'(bus.acc_rdy), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
